// File: rtl/mx_pkg.sv
// Shared Manchester-block definitions: scheduler state encoding and requester limit.
package mx_pkg;

  localparam int unsigned MX_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/mx_rr_pick.sv
// Combinational round-robin picker: first set request searching from last+1 with wrap.
module mx_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IW    = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_REQ-1:0] o_pick_oh,
  output logic [IW-1:0]    o_pick_idx
);

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    o_pick_oh  = '0;
    o_pick_idx = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      logic [IW-1:0] w_j;
      w_j = IW'((int'(i_last) + k) % int'(N_REQ));
      if (i_req[w_j]) begin
        o_pick_oh      = '0;
        o_pick_oh[w_j] = 1'b1;
        o_pick_idx     = w_j;
      end
    end
  end

endmodule

// File: rtl/mx_tx_sched.sv
// Frame-level round-robin scheduler sharing one Manchester transmitter among N_REQ sources.
// Optional grant timeout with forced release is built when MXSCHED_TIMEOUT_EN is defined.
module mx_tx_sched
  import mx_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      send_in,
  input  logic [N_REQ-1:0][7:0] data_in,
  output logic [N_REQ-1:0]      ready_out,
  output logic [N_REQ-1:0]      grant,
  output logic                  tx_send,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  busy
`ifdef MXSCHED_TIMEOUT_EN
  ,output logic                 timeout_err
`endif
);

  localparam int unsigned IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GW       = $clog2((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [IW-1:0]    r_last;
  logic [GW-1:0]    r_gap_cnt;
  logic [N_REQ-1:0] w_req_eff;
  logic [N_REQ-1:0] w_pick_oh;
  logic [IW-1:0]    w_pick_idx;
  logic             w_grant_load;
  logic             w_grant_clr;
  logic             w_force;

`ifdef MXSCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0]    r_to_cnt;
  logic [N_REQ-1:0] r_locked;

  assign w_force     = (r_state == GRANT) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_req_eff   = req & ~r_locked;
  assign timeout_err = w_force;

  // Grant-length counter and per-requester lockout after a forced release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_locked <= '0;
    end else begin
      if (w_grant_load)
        r_to_cnt <= '0;
      else if ((r_state == GRANT) && (r_to_cnt != '1))
        r_to_cnt <= r_to_cnt + TW'(1);
      r_locked <= (r_locked | (w_force ? r_grant : '0)) & req;
    end
  end
`else
  assign w_force   = 1'b0;
  assign w_req_eff = req;
`endif

  mx_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req      (w_req_eff),
    .i_last     (r_last),
    .o_pick_oh  (w_pick_oh),
    .o_pick_idx (w_pick_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and grant load/clear strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_load = 1'b0;
    w_grant_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req_eff) begin
          w_grant_load = 1'b1;
          w_state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (w_force || !req[r_last]) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (tx_ready) begin
          w_grant_clr = 1'b1;
          w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == GW'(GAP_LAST)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant vector and round-robin pointer; pointer moves only on a new grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_last  <= IW'(N_REQ - 1);
    end else if (w_grant_load) begin
      r_grant <= w_pick_oh;
      r_last  <= w_pick_idx;
    end else if (w_grant_clr) begin
      r_grant <= '0;
    end
  end

  // Inter-frame gap counter, cleared on drain exit and saturating.
  always_ff @(posedge clk) begin
    if (reset)
      r_gap_cnt <= '0;
    else if (w_grant_clr)
      r_gap_cnt <= '0;
    else if ((r_state == GAP) && (r_gap_cnt != '1))
      r_gap_cnt <= r_gap_cnt + GW'(1);
  end

  // Zero-latency pass-through of the granted requester, masked outside GRANT.
  always_comb begin
    tx_send   = 1'b0;
    tx_data   = '0;
    ready_out = '0;
    if (r_state == GRANT) begin
      tx_send           = send_in[r_last];
      tx_data           = data_in[r_last];
      ready_out[r_last] = tx_ready;
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_mx_tx_sched.sv
// Directed testbench for mx_tx_sched: one instance with a 16-cycle gap, one with no gap.
module tb_mx_tx_sched;

  localparam int unsigned N = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N-1:0]     send_in;
  logic [N-1:0][7:0] data_in;
  logic             tx_ready;

  logic [N-1:0]     ready_out, grant, ready_out0, grant0;
  logic             tx_send, tx_send0, busy, busy0;
  logic [7:0]       tx_data, tx_data0;
`ifdef MXSCHED_TIMEOUT_EN
  logic             timeout_err, timeout_err0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [1:0] send;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic       exp_send;
    logic [7:0] exp_data;
    logic [1:0] exp_ready;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  mx_tx_sched #(.N_REQ(N), .GAP_CYCLES(16), .TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .send_in   (send_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .grant     (grant),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .busy      (busy)
`ifdef MXSCHED_TIMEOUT_EN
    ,.timeout_err (timeout_err)
`endif
  );

  mx_tx_sched #(.N_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(50)) dut_g0 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .send_in   (send_in),
    .data_in   (data_in),
    .ready_out (ready_out0),
    .grant     (grant0),
    .tx_send   (tx_send0),
    .tx_data   (tx_data0),
    .tx_ready  (tx_ready),
    .busy      (busy0)
`ifdef MXSCHED_TIMEOUT_EN
    ,.timeout_err (timeout_err0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [1:0] exp_g;

    // send, d0, d1, rdy -> tx_send, tx_data, ready_out (requester 0 granted)
    vecs[0] = '{2'b01, 8'hAA, 8'h55, 1'b1, 1'b1, 8'hAA, 2'b01};
    vecs[1] = '{2'b01, 8'h0B, 8'h55, 1'b0, 1'b1, 8'h0B, 2'b00};
    vecs[2] = '{2'b11, 8'h04, 8'hFF, 1'b1, 1'b1, 8'h04, 2'b01};
    vecs[3] = '{2'b10, 8'h04, 8'hFF, 1'b1, 1'b0, 8'h04, 2'b01};
    vecs[4] = '{2'b00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 2'b00};

    // Reset state with live-looking inputs that must be masked.
    reset = 1'b1; req = '0; send_in = 2'b11; tx_ready = 1'b1;
    data_in[0] = 8'h5A; data_in[1] = 8'hA5;
    tick(); tick();
    chk("rst_grant",   32'(grant),     32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_tx_send", 32'(tx_send),   32'd0);
    chk("rst_tx_data", 32'(tx_data),   32'd0);
    chk("rst_ready",   32'(ready_out), 32'd0);
    chk("rst_grant0",  32'(grant0),    32'd0);

    // Single requester frame through the vector table.
    reset = 1'b0; send_in = '0; tx_ready = 1'b0;
    tick();
    chk("idle_grant", 32'(grant), 32'd0);
    req = 2'b01;
    tick();
    chk("grant_r0", 32'(grant), 32'd1);
    chk("busy_r0",  32'(busy),  32'd1);
    for (int i = 0; i < 5; i++) begin
      send_in    = vecs[i].send;
      data_in[0] = vecs[i].d0;
      data_in[1] = vecs[i].d1;
      tx_ready   = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_send", i),  32'(tx_send),   32'(vecs[i].exp_send));
      chk($sformatf("vec%0d_data", i),  32'(tx_data),   32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_ready", i), 32'(ready_out), 32'(vecs[i].exp_ready));
      tick();
    end

    // End of frame: DRAIN keeps grant but masks everything.
    req = '0; send_in = 2'b01; data_in[0] = 8'hAA; tx_ready = 1'b0;
    tick();
    chk("drain_grant",   32'(grant),   32'd1);
    chk("drain_busy",    32'(busy),    32'd1);
    chk("drain_tx_send", 32'(tx_send), 32'd0);
    chk("drain_tx_data", 32'(tx_data), 32'd0);
    tx_ready = 1'b1;
    #1;
    chk("drain_ready", 32'(ready_out), 32'd0);
    send_in = '0;
    req = 2'b11;
    tick();
    chk("gap_grant", 32'(grant), 32'd0);
    chk("gap_busy",  32'(busy),  32'd1);
    n = 1;
    while (grant == '0 && n < 100) begin
      tick();
      n++;
    end
    chk("gap_spacing", 32'(n),     32'd18);
    chk("rr_first",    32'(grant), 32'd2);

    // Contention: alternate grants, each requester re-raises right after its frame.
    for (int f = 0; f < 4; f++) begin
      exp_g = (f % 2 == 0) ? 2'b10 : 2'b01;
      chk($sformatf("cont%0d_grant", f), 32'(grant), 32'(exp_g));
      tick();
      req = 2'b11 & ~exp_g;
      tick();
      chk($sformatf("cont%0d_drain", f), 32'(grant), 32'(exp_g));
      req = 2'b11;
      tick();
      n = 1;
      while (grant == '0 && n < 100) begin
        tick();
        n++;
      end
      chk($sformatf("cont%0d_spacing", f), 32'(n), 32'd18);
    end
    chk("cont_final", 32'(grant), 32'd2);

    // No-gap instance: request dropping right at arbitration, then next grant 2 cycles after tx_ready.
    reset = 1'b1; req = '0; tx_ready = 1'b0; send_in = '0;
    tick();
    reset = 1'b0; req = 2'b01;
    tick();
    chk("g0_grant",  32'(grant0), 32'd1);
    req = '0;
    tick();
    chk("g0_drain",  32'(grant0), 32'd1);
    chk("g0_busy",   32'(busy0),  32'd1);
    tx_ready = 1'b1; req = 2'b10;
    tick();
    chk("g0_idle_grant", 32'(grant0), 32'd0);
    chk("g0_idle_busy",  32'(busy0),  32'd0);
    tick();
    chk("g0_next_grant", 32'(grant0), 32'd2);
    send_in = 2'b10;
    #1;
    chk("g0_pass_send", 32'(tx_send0), 32'd1);

    // Reset in the middle of requester 1's frame.
    reset = 1'b1; req = '0; send_in = '0;
    tick();
    reset = 1'b0; req = 2'b10; tx_ready = 1'b1;
    tick();
    chk("mid_grant", 32'(grant), 32'd2);
    send_in = 2'b10; data_in[1] = 8'h11; data_in[0] = 8'h77;
    #1;
    chk("mid_byte1",  32'(tx_data),   32'h11);
    chk("mid_ready",  32'(ready_out), 32'd2);
    tick();
    data_in[1] = 8'h22;
    #1;
    chk("mid_send2", 32'(tx_send), 32'd1);
    chk("mid_byte2", 32'(tx_data), 32'h22);
    reset = 1'b1; req = 2'b11;
    tick();
    chk("mid_rst_send",  32'(tx_send), 32'd0);
    chk("mid_rst_grant", 32'(grant),   32'd0);
    chk("mid_rst_busy",  32'(busy),    32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_first", 32'(grant), 32'd1);

`ifdef MXSCHED_TIMEOUT_EN
    // Forced release after 50 grant cycles, lockout until req drops.
    reset = 1'b1; req = '0; send_in = '0; tx_ready = 1'b0;
    tick();
    reset = 1'b0; req = 2'b10;
    tick();
    chk("to_grant", 32'(grant), 32'd2);
    n = 1;
    while (!timeout_err && n < 200) begin
      tick();
      n++;
    end
    chk("to_cycle", 32'(n), 32'd50);
    tick();
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    chk("to_drain",     32'(grant),       32'd2);
    tx_ready = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("to_locked_grant", 32'(grant), 32'd0);
    chk("to_locked_busy",  32'(busy),  32'd0);
    req = 2'b11;
    tick();
    chk("to_r0_grant", 32'(grant), 32'd1);
    req = '0;
    tick();
    req = 2'b10;
    n = 0;
    while (grant != 2'b10 && n < 100) begin
      tick();
      n++;
    end
    chk("to_unlock_grant", 32'(grant), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
